// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and types for the instruction fetch unit.
//
// Contents:
//   WORD_BYTES        bytes per instruction word
//   PC_STEP           byte increment between sequential fetches
//   DEFAULT_RESET_PC  default address of the first fetch after reset
//   fetch_state_t     FSM state type with S_START / S_RUN / S_FLUSH encodings
//   fetch_entry_t     one prefetch buffer entry: {pc, instruction}
//   word_align()      clears the sub-word address bits
package ifetch_pkg;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_START = 2'd0;  // first cycle after reset
    localparam fetch_state_t S_RUN   = 2'd1;  // normal issue and capture
    localparam fetch_state_t S_FLUSH = 2'd2;  // drop the response of the redirected cycle

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(32'(WORD_BYTES) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry FIFO of fetched {pc, instruction} pairs.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   flush        empties the FIFO at the next edge; wins over push and pop
//   push         write push_entry at the tail
//   push_entry   entry to write
//   pop          drop the head entry (ignored while empty)
//   head         current head entry (reset value is all zeros)
//   count        number of stored entries
//   full, empty  occupancy flags
//
// A push into a full FIFO is accepted only when a pop happens on the same
// edge, so a simultaneous pop and push never loses an entry.
module fetch_buffer
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential instruction prefetcher with branch redirect.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   read_address      registered word address presented to instruction memory
//   instruction       memory data for the address sampled on the previous edge
//   branch_taken      one-cycle redirect request
//   branch_target     redirect byte address (sub-word bits are cleared)
//   out_valid         out_instruction/out_pc hold a fetched word
//   out_ready         consumer accepts the word this cycle
//   out_instruction   fetched instruction word
//   out_pc            byte address of out_instruction
//   misalign_err      one-cycle pulse after a redirect to a misaligned target
//   state             current FSM state (debug visibility)
//
// Handshake: a word moves to the consumer on a rising edge where out_valid
// and out_ready are both high; out_valid never depends on out_ready, and the
// presented word holds steady until it is taken or a redirect discards it.
//
// Build option: define IFETCH_ALIGN_CHECK_EN to enable misalign_err; without
// it the output is tied low and targets are still word-aligned.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic [31:0]  read_address,
    input  logic [31:0]  instruction,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_instruction,
    output logic [31:0]  out_pc,
    output logic         misalign_err,
    output fetch_state_t state
);

    localparam int          CW          = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(BUF_DEPTH);

    fetch_state_t  state_q;
    fetch_state_t  state_d;
    logic [31:0]   read_address_q;
    logic          inflight_q;       // a request issued last cycle returns this cycle
    logic [31:0]   inflight_pc_q;    // address of that request

    logic          redirect;
    logic          transfer;
    logic          capture;
    logic          issue;
    logic [CW:0]   occupancy;

    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] buf_count;
    logic          buf_full;
    logic          buf_empty;

    // The first cycle after reset ignores redirects; its only job is to
    // issue the reset address.
    assign redirect = branch_taken && ((state_q == S_RUN) || (state_q == S_FLUSH));
    assign transfer = !buf_empty && out_ready;

    // In S_FLUSH inflight_q is already clear, so the stale response that
    // arrives there is never written to the buffer.
    assign capture  = (state_q == S_RUN) && inflight_q && !redirect;

    // Slots that will be occupied after this edge before any new request:
    // stored words, minus the one leaving now, plus the one arriving now.
    assign occupancy = {1'b0, buf_count}
                     + {{CW{1'b0}}, inflight_q}
                     - {{CW{1'b0}}, transfer};

    // A new request is made only if its response is guaranteed a slot.
    assign issue = !redirect
                && !(buf_full && !transfer)
                && (occupancy < DEPTH_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START: state_d = S_RUN;
            S_RUN:   state_d = branch_taken ? S_FLUSH : S_RUN;
            S_FLUSH: state_d = branch_taken ? S_FLUSH : S_RUN;
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_START;
            read_address_q <= word_align(RESET_PC);
            inflight_q     <= 1'b0;
            inflight_pc_q  <= '0;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                // The request made this cycle belongs to the old path and is
                // abandoned by clearing inflight_q.
                read_address_q <= word_align(branch_target);
                inflight_q     <= 1'b0;
            end else begin
                inflight_q <= issue;
                if (issue) begin
                    read_address_q <= read_address_q + PC_STEP;
                    inflight_pc_q  <= read_address_q;
                end
            end
        end
    end

    assign push_entry.pc          = inflight_pc_q;
    assign push_entry.instruction = instruction;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (capture),
        .push_entry (push_entry),
        .pop        (transfer),
        .head       (head),
        .count      (buf_count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

`ifdef IFETCH_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect && (branch_target[1:0] != 2'b00);
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    assign read_address    = read_address_q;
    assign out_valid       = !buf_empty;
    assign out_instruction = head.instruction;
    assign out_pc          = head.pc;
    assign state           = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: self-checking bench for instruction_fetch.
// Instruction memory is modelled as a pure function of the address so every
// delivered word can be tied back to its pc. Define IFETCH_ALIGN_CHECK_EN
// for both RTL and bench to exercise the misalignment pulse.
module tb_instruction_fetch;
    import ifetch_pkg::*;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;
`ifdef IFETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  read_address;
    logic [31:0]  instruction = '0;
    logic         branch_taken = 1'b0;
    logic [31:0]  branch_target = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_instruction;
    logic [31:0]  out_pc;
    logic         misalign_err;
    fetch_state_t dut_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    instruction_fetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .read_address    (read_address),
        .instruction     (instruction),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .misalign_err    (misalign_err),
        .state           (dut_state)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One-cycle read latency: the word for the address seen at this edge.
    always @(posedge clk) instruction <= word_of(read_address);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver helpers ----------------
    // Leaves the bench at the negedge where reset is released (cycle 0).
    task automatic do_reset();
        reset        = 1'b1;
        branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (read_address !== RESET_PC) begin errors++; $display("FAIL reset_ra: got %h expected %h", read_address, RESET_PC); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
        checks++; if (out_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", out_instruction); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
        checks++; if (dut_state !== S_START) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut_state, S_START); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            checks++; if (read_address !== RESET_PC + 32'(4 * k)) begin errors++; $display("FAIL stream_ra[%0d]: got %h expected %h", k, read_address, RESET_PC + 32'(4 * k)); end
            checks++; if (out_valid !== (k >= 2)) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected %b", k, out_valid, (k >= 2)); end
            if (k >= 2) begin
                exp_pc = RESET_PC + 32'(4 * (k - 2));
                checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, out_pc, exp_pc); end
                checks++; if (out_instruction !== word_of(exp_pc)) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", k, out_instruction, word_of(exp_pc)); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_ra;
        logic [31:0] exp_pc;
        out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            exp_ra = (k < 2) ? RESET_PC + 32'(4 * k) : RESET_PC + 32'd8;
            checks++; if (read_address !== exp_ra) begin errors++; $display("FAIL bp_ra[%0d]: got %h expected %h", k, read_address, exp_ra); end
            if (k >= 2) begin
                checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, out_valid, out_pc, RESET_PC); end
            end
            @(negedge clk);
        end
        exp_q.delete();
        for (int j = 0; j < 3; j++) exp_q.push_back(RESET_PC + 32'(4 * j));
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            exp_pc = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin errors++; $display("FAIL bp_drain[%0d]: got v=%b pc=%h expected v=1 pc=%h", j, out_valid, out_pc, exp_pc); end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0;
        do_reset();
        repeat (2) @(negedge clk);
        out_ready = 1'b1;                   // cycle 2: take pc 0
        @(negedge clk);                     // cycle 3: pc 4 buffered, pc 8 in flight
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin errors++; $display("FAIL redir_setup: got v=%b pc=%h expected v=1 pc=4", out_valid, out_pc); end
        out_ready     = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        @(negedge clk);
        branch_taken = 1'b0;
        out_ready    = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid0: got %b expected 0", out_valid); end
        checks++; if (read_address !== 32'h40) begin errors++; $display("FAIL redir_ra: got %h expected 40", read_address); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL redir_misalign: got %b expected 0", misalign_err); end
        checks++; if (dut_state !== S_FLUSH) begin errors++; $display("FAIL redir_state: got %0d expected %0d", dut_state, S_FLUSH); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid1: got %b expected 0", out_valid); end
        checks++; if (read_address !== 32'h44) begin errors++; $display("FAIL redir_ra1: got %h expected 44", read_address); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instruction !== word_of(32'h40)) begin errors++; $display("FAIL redir_first: got v=%b pc=%h expected v=1 pc=40", out_valid, out_pc); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h44) begin errors++; $display("FAIL redir_second: got v=%b pc=%h expected v=1 pc=44", out_valid, out_pc); end
    endtask

    task automatic test_misalign();
        out_ready = 1'b1;
        do_reset();
        repeat (4) @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h42;
        @(negedge clk);
        branch_taken = 1'b0;
        checks++; if (misalign_err !== ALIGN_CHECK) begin errors++; $display("FAIL mis_pulse: got %b expected %b", misalign_err, ALIGN_CHECK); end
        checks++; if (read_address !== 32'h40) begin errors++; $display("FAIL mis_ra: got %h expected 40", read_address); end
        @(negedge clk);
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", misalign_err); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL mis_first: got v=%b pc=%h expected v=1 pc=40", out_valid, out_pc); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h44) begin errors++; $display("FAIL mis_second: got v=%b pc=%h expected v=1 pc=44", out_valid, out_pc); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        @(negedge clk);
        branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got v=%b pc=%h expected v=1 pc=fffffffc", out_valid, out_pc); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instruction !== word_of(32'h0)) begin errors++; $display("FAIL wrap_second: got v=%b pc=%h expected v=1 pc=0", out_valid, out_pc); end
    endtask

    task automatic test_flush_restart();
        out_ready = 1'b1;
        do_reset();
        repeat (5) @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        @(negedge clk);                     // in S_FLUSH: redirect again
        branch_target = 32'h200;
        @(negedge clk);
        branch_taken = 1'b0;
        checks++; if (out_valid !== 1'b0 || read_address !== 32'h200) begin errors++; $display("FAIL restart_ra: got v=%b ra=%h expected v=0 ra=200", out_valid, read_address); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL restart_gap: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin errors++; $display("FAIL restart_first: got v=%b pc=%h expected v=1 pc=200", out_valid, out_pc); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204) begin errors++; $display("FAIL restart_second: got v=%b pc=%h expected v=1 pc=204", out_valid, out_pc); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: got %b expected 1", out_valid); end
        #2 reset = 1'b1;                    // well away from any clock edge
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
        checks++; if (read_address !== RESET_PC) begin errors++; $display("FAIL mid_ra: got %h expected %h", read_address, RESET_PC); end
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin errors++; $display("FAIL mid_restart0: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, RESET_PC); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC + 32'd4) begin errors++; $display("FAIL mid_restart1: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, RESET_PC + 32'd4); end
    endtask

    // Reference model: the consumer must see the sequential stream that
    // starts at RESET_PC, restarts at the aligned target of each redirect,
    // presents each word once in order, and never stalls more than two
    // cycles after a redirect.
    task automatic test_random();
        logic [31:0] tgt;
        logic [31:0] head_pc;
        bit          rdy;
        bit          br;
        bit          prev_br = 1'b0;
        bit          prev_mis = 1'b0;
        int          idle = 0;
        out_ready = 1'b1;
        do_reset();
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        for (int n = 0; n < 3000; n++) begin
            checks++; if (read_address[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_ra_align[%0d]: got %h expected low bits 0", n, read_address); end
            if (prev_br) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_post_branch_valid[%0d]: got %b expected 0", n, out_valid); end
            end
            checks++; if (misalign_err !== (ALIGN_CHECK && prev_br && prev_mis)) begin errors++; $display("FAIL rnd_misalign[%0d]: got %b expected %b", n, misalign_err, (ALIGN_CHECK && prev_br && prev_mis)); end
            head_pc = exp_q[0];
            if (out_valid === 1'b1) begin
                idle = 0;
                checks++; if (out_pc !== head_pc || out_instruction !== word_of(head_pc)) begin errors++; $display("FAIL rnd_word[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", n, out_pc, out_instruction, head_pc, word_of(head_pc)); end
            end else begin
                idle++;
            end
            checks++; if (idle > 2) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d idle cycles expected at most 2", n, idle); end

            rdy = ($urandom_range(0, 3) != 0);
            br  = (n > 0) && ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       tgt = $urandom() & 32'hFFFF_FFFC;
                1:       tgt = $urandom();
                default: tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            endcase
            out_ready     = rdy;
            branch_taken  = br;
            branch_target = tgt;

            if (out_valid === 1'b1 && rdy) begin
                void'(exp_q.pop_front());
                exp_q.push_back(head_pc + 32'd4);
            end
            if (br) begin
                exp_q.delete();
                exp_q.push_back({tgt[31:2], 2'b00});
                idle = 0;
            end
            prev_br  = br;
            prev_mis = (tgt[1:0] != 2'b00);
            @(negedge clk);
        end
        branch_taken = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_wrap();
        test_flush_restart();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
